// File: rtl/dff_pipe_bank_if.sv
// Valid/ready bus for dff_pipe_bank: upstream write side and downstream read side.
// The master drives words in and drains them; the slave is the register bank.
interface dff_pipe_bank_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/dff_pipe_bank.sv
// WIDTH x DEPTH register pipeline with valid/ready flow control, bubble collapsing,
// polarity-selectable enable, reset/clear load values and an occupancy counter.
module dff_pipe_bank #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter bit               EN_INV  = 1'b0,
    parameter logic [WIDTH-1:0] INIT    = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '1
) (
    input  logic                       clk,
    input  logic                       sr,
    input  logic                       en,
    input  logic                       clr,
    dff_pipe_bank_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             ena;
    logic             run;
    logic             room;
    logic             in_ready;
    logic             accept;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] mv;
    logic [WIDTH-1:0] d [DEPTH];

    assign ena      = en ^ EN_INV;
    assign run      = sr & ~clr & ena;
    assign in_ready = run & room;
    assign accept   = bus.in_valid & in_ready;

    // Walk from the output end back: a stage moves when its successor is empty
    // or moving, and room carries that condition down to stage 0.
    always_comb begin : move_chain
        logic go;
        mv = '0;
        go = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            mv[i] = v[i] & go;
            go    = go | ~v[i];
        end
        room = go;
    end

    always_ff @(posedge clk) begin
        if (!sr) begin
            v     <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= INIT;
        end else if (clr) begin
            v     <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= CLR_VAL;
        end else if (ena) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                if (mv[i-1]) begin
                    d[i] <= d[i-1];
                    v[i] <= 1'b1;
                end else if (mv[i]) begin
                    v[i] <= 1'b0;
                end
            end
            if (accept) begin
                d[0] <= bus.in_data;
                v[0] <= 1'b1;
            end else if (mv[0]) begin
                v[0] <= 1'b0;
            end
            count <= count + CW'(accept) - CW'(mv[DEPTH-1]);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];

    // The counter is redundant with the valid bits and must never drift from them.
    always @(posedge clk) begin
        if (sr) begin
            assert (int'(count) == $countones(v));
            assert (int'(count) <= DEPTH);
        end
    end
endmodule

// File: tb/tb_dff_pipe_bank.sv
// Directed checks on an 8x4 active-low-enable bank, then a scoreboarded random
// sweep on 33x7 and 1x1 banks.
module tb_dff_pipe_bank;
    logic clk = 1'b0;
    logic sr, clr, en0, en1, en2;
    logic [2:0] count0;
    logic [2:0] count1;
    logic [0:0] count2;
    int checks = 0;
    int errors = 0;
    logic [32:0] q1 [$];
    logic [0:0]  q2 [$];

    always #5 clk = ~clk;

    dff_pipe_bank_if #(.WIDTH(8))  bus0 ();
    dff_pipe_bank_if #(.WIDTH(33)) bus1 ();
    dff_pipe_bank_if #(.WIDTH(1))  bus2 ();

    dff_pipe_bank #(.WIDTH(8), .DEPTH(4), .EN_INV(1'b1), .INIT(8'h00), .CLR_VAL(8'hFF)) u0 (
        .clk(clk), .sr(sr), .en(en0), .clr(clr), .bus(bus0), .count(count0));
    dff_pipe_bank #(.WIDTH(33), .DEPTH(7), .EN_INV(1'b0)) u1 (
        .clk(clk), .sr(sr), .en(en1), .clr(clr), .bus(bus1), .count(count1));
    dff_pipe_bank #(.WIDTH(1), .DEPTH(1), .EN_INV(1'b0)) u2 (
        .clk(clk), .sr(sr), .en(en2), .clr(clr), .bus(bus2), .count(count2));

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1 ns later, well before the rising edge.
    task automatic apply_stimulus(input logic r, input logic e, input logic c,
                                  input logic iv, input logic [7:0] data, input logic ordy);
        @(negedge clk);
        sr             = r;
        en0            = e;
        clr            = c;
        bus0.in_valid  = iv;
        bus0.in_data   = data;
        bus0.out_ready = ordy;
        #1;
    endtask

    task automatic sweep_cycle(input bit feed);
        @(negedge clk);
        en1            = feed ? ($urandom_range(0, 7) != 0) : 1'b1;
        bus1.in_valid  = feed & 1'($urandom_range(0, 1));
        bus1.in_data   = {1'($urandom), 32'($urandom)};
        bus1.out_ready = feed ? ($urandom_range(0, 3) != 0) : 1'b1;
        en2            = feed ? ($urandom_range(0, 7) != 0) : 1'b1;
        bus2.in_valid  = feed & 1'($urandom_range(0, 1));
        bus2.in_data   = 1'($urandom);
        bus2.out_ready = feed ? ($urandom_range(0, 1) != 0) : 1'b1;
        #1;
        check_output("sweep1_count", 64'(count1), 64'(q1.size()));
        check_output("sweep2_count", 64'(count2), 64'(q2.size()));
        if (bus1.out_valid && bus1.out_ready && en1)
            check_output("sweep1_order", {31'd0, bus1.out_data},
                         (q1.size() != 0) ? {31'd0, q1.pop_front()} : 64'hDEAD_0000_0000_0000);
        if (bus2.out_valid && bus2.out_ready && en2)
            check_output("sweep2_order", {63'd0, bus2.out_data},
                         (q2.size() != 0) ? {63'd0, q2.pop_front()} : 64'hDEAD_0000_0000_0000);
        if (bus1.in_valid && bus1.in_ready) q1.push_back(bus1.in_data);
        if (bus2.in_valid && bus2.in_ready) q2.push_back(bus2.in_data);
    endtask

    initial begin
        sr = 1'b0; clr = 1'b0; en0 = 1'b0; en1 = 1'b1; en2 = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b1);
        check_output("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check_output("rst_out_data",  64'(bus0.out_data),  64'h00);
        check_output("rst_count",     64'(count0),         64'd0);
        check_output("rst_in_ready",  64'(bus0.in_ready),  64'd0);

        // 0x01..0x08 back to back, then four idle cycles to drain
        for (int k = 1; k <= 13; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, k <= 8, 8'(k), 1'b1);
            check_output("stream_count", 64'(count0),
                         64'((k <= 5) ? k - 1 : (k <= 9) ? 4 : 13 - k));
            check_output("stream_out_valid", 64'(bus0.out_valid), 64'(k >= 5 && k <= 12));
            if (k >= 5 && k <= 12)
                check_output("stream_out_data", 64'(bus0.out_data), 64'(k - 4));
            if (k <= 8)
                check_output("stream_in_ready", 64'(bus0.in_ready), 64'd1);
        end

        for (int k = 1; k <= 4; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h10 + k), 1'b0);
            check_output("bp_fill_count", 64'(count0), 64'(k - 1));
            check_output("bp_fill_ready", 64'(bus0.in_ready), 64'd1);
        end
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0);
            check_output("bp_full_ready", 64'(bus0.in_ready), 64'd0);
            check_output("bp_full_count", 64'(count0), 64'd4);
            check_output("bp_hold_data", 64'(bus0.out_data), 64'h11);
            check_output("bp_hold_valid", 64'(bus0.out_valid), 64'd1);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h15, 1'b1);
        check_output("bp_pass_ready", 64'(bus0.in_ready), 64'd1);
        check_output("bp_pass_count", 64'(count0), 64'd4);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h16, 1'b0);
        check_output("bp_after_count", 64'(count0), 64'd4);
        check_output("bp_after_data", 64'(bus0.out_data), 64'h12);
        check_output("bp_after_ready", 64'(bus0.in_ready), 64'd0);

        // en=1 freezes this bank because its enable is active-low
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h16, 1'b1);
        check_output("frz_pre_ready", 64'(bus0.in_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h17, 1'b1);
            check_output("frz_ready", 64'(bus0.in_ready), 64'd0);
            check_output("frz_data", 64'(bus0.out_data), 64'h13);
            check_output("frz_count", 64'(count0), 64'd4);
            check_output("frz_valid", 64'(bus0.out_valid), 64'd1);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h17, 1'b1);
        check_output("frz_resume_ready", 64'(bus0.in_ready), 64'd1);
        check_output("frz_resume_data", 64'(bus0.out_data), 64'h13);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            check_output("frz_drain_count", 64'(count0), 64'(4 - k));
            check_output("frz_drain_valid", 64'(bus0.out_valid), 64'(k < 4));
            if (k < 4)
                check_output("frz_drain_data", 64'(bus0.out_data), 64'(8'h14 + k));
        end

        for (int k = 1; k <= 3; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h20 + k), 1'b0);
            check_output("clr_fill_count", 64'(count0), 64'(k - 1));
        end
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check_output("clr_rst_ready", 64'(bus0.in_ready), 64'd0);
        check_output("clr_rst_count", 64'(count0), 64'd3);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h31, 1'b0);
        check_output("clr_rst_wins_data", 64'(bus0.out_data), 64'h00);
        check_output("clr_rst_wins_count", 64'(count0), 64'd0);
        check_output("clr_rst_wins_valid", 64'(bus0.out_valid), 64'd0);
        check_output("clr_rst_wins_ready", 64'(bus0.in_ready), 64'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h32, 1'b0);
        check_output("clr_refill_count", 64'(count0), 64'd1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
        check_output("clr_ready", 64'(bus0.in_ready), 64'd0);
        check_output("clr_pre_count", 64'(count0), 64'd2);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check_output("clr_data", 64'(bus0.out_data), 64'hFF);
        check_output("clr_count", 64'(count0), 64'd0);
        check_output("clr_valid", 64'(bus0.out_valid), 64'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h42, 1'b1);
        check_output("post_clr_ready", 64'(bus0.in_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            check_output("post_clr_latency", 64'(bus0.out_valid), 64'd0);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_output("post_clr_valid", 64'(bus0.out_valid), 64'd1);
        check_output("post_clr_data", 64'(bus0.out_data), 64'h42);
        check_output("post_clr_count", 64'(count0), 64'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_output("post_clr_empty", 64'(count0), 64'd0);

        $display("[TB] random sweep on 33x7 and 1x1 banks");
        for (int n = 0; n < 400; n++) sweep_cycle(1'b1);
        for (int n = 0; n < 30 && (q1.size() != 0 || q2.size() != 0); n++) sweep_cycle(1'b0);
        sweep_cycle(1'b0);
        check_output("drain_q1_empty", 64'(q1.size()), 64'd0);
        check_output("drain_q2_empty", 64'(q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
